int_ctrl: RTL

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/int_ctrl.sv
// int_ctrl: reset/NMI/IRQ/BRK interrupt sequencer for a 6502-style core.
// Ports: PHI_0 clk, RES async reset, NMI/IRQ active-low async requests,
//   I_FLAG mask, SYNC/ACK/BRK core handshake; INT_REQ, INT_KIND,
//   INT_VEC, B_OUT, BUSY describe the pending/active service sequence.
module int_ctrl #(
    parameter int SVC_CYCLES = 7
) (
    input  logic        PHI_0,
    input  logic        RES,
    input  logic        NMI,
    input  logic        IRQ,
    input  logic        I_FLAG,
    input  logic        SYNC,
    input  logic        ACK,
    input  logic        BRK,
    output logic        INT_REQ,
    output logic [1:0]  INT_KIND,
    output logic [15:0] INT_VEC,
    output logic        B_OUT,
    output logic        BUSY
);

    localparam int CW = (SVC_CYCLES > 1) ? $clog2(SVC_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(SVC_CYCLES - 1);
    localparam logic [CW-1:0] HIJ_MAX = CW'(SVC_CYCLES - 4);

    localparam logic [1:0] K_NONE = 2'b00;
    localparam logic [1:0] K_RST  = 2'b01;
    localparam logic [1:0] K_NMI  = 2'b10;
    localparam logic [1:0] K_IRQ  = 2'b11;

    typedef enum logic {IDLE, SERVICE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    kind_q, kind_n;
    logic          b_q, b_n;
    logic [1:0]    nmi_s, irq_s;
    logic [1:0]    arm;
    logic          nmi_d;
    logic          nmi_pend, rst_pend;
    logic          nmi_clr, rst_clr;
    logic          nmi_fall, irq_act;
    logic [1:0]    hw_kind;

    // nmi_d only follows the synchronizer once it carries real samples,
    // so a low NMI held through reset release is not seen as an edge.
    assign nmi_fall = nmi_d & ~nmi_s[1];
    assign irq_act  = ~irq_s[1] & ~I_FLAG;

    always_comb begin
        if (rst_pend)
            hw_kind = K_RST;
        else if (nmi_pend)
            hw_kind = K_NMI;
        else if (irq_act)
            hw_kind = K_IRQ;
        else
            hw_kind = K_NONE;
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        kind_n   = kind_q;
        b_n      = b_q;
        nmi_clr  = 1'b0;
        rst_clr  = 1'b0;
        INT_REQ  = 1'b0;
        INT_KIND = K_NONE;
        B_OUT    = 1'b0;
        BUSY     = 1'b0;
        unique case (state)
            IDLE: begin
                INT_REQ  = (hw_kind != K_NONE);
                INT_KIND = hw_kind;
                if (ACK && SYNC && (INT_REQ || BRK)) begin
                    // A pending hardware source swallows a coincident BRK.
                    state_n = SERVICE;
                    cnt_n   = '0;
                    kind_n  = INT_REQ ? hw_kind : K_IRQ;
                    b_n     = ~INT_REQ;
                    nmi_clr = (hw_kind == K_NMI);
                    rst_clr = (hw_kind == K_RST);
                end
            end
            SERVICE: begin
                BUSY     = 1'b1;
                INT_KIND = kind_q;
                B_OUT    = b_q;
                // Late enough that the vector fetch has not started yet.
                if (kind_q == K_IRQ && nmi_pend && cnt <= HIJ_MAX) begin
                    kind_n  = K_NMI;
                    nmi_clr = 1'b1;
                end
                if (cnt == LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        INT_VEC = 16'hFFFE;
        unique case (INT_KIND)
            K_RST:   INT_VEC = 16'hFFFC;
            K_NMI:   INT_VEC = 16'hFFFA;
            default: INT_VEC = 16'hFFFE;
        endcase
    end

    always_ff @(posedge PHI_0 or posedge RES) begin
        if (RES) begin
            state    <= IDLE;
            cnt      <= '0;
            kind_q   <= K_RST;
            b_q      <= 1'b0;
            nmi_s    <= 2'b11;
            irq_s    <= 2'b11;
            arm      <= 2'b00;
            nmi_d    <= 1'b0;
            nmi_pend <= 1'b0;
            rst_pend <= 1'b1;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            kind_q   <= kind_n;
            b_q      <= b_n;
            nmi_s    <= {nmi_s[0], NMI};
            irq_s    <= {irq_s[0], IRQ};
            arm      <= {arm[0], 1'b1};
            nmi_d    <= nmi_s[1] & arm[1];
            nmi_pend <= nmi_fall | (nmi_pend & ~nmi_clr);
            rst_pend <= rst_pend & ~rst_clr;
        end
    end

endmodule
